btn_event_gen: RTL and testbench
================================

# btn_event_gen

Per-button event generator sitting directly downstream of the button debouncers in the simple-calculator design. It consumes clean, debounced button levels and turns them into single-cycle command pulses for the calculator control logic:
- press
- release
- long-press
- optional auto-repeat

All buttons are handled independently and in parallel. There is no cross-button priority.

## Interface
- NUM_BTNS, 4, number of independent button channels (1..16)
- LONG_COUNT, 8, cycles a button must stay held after its press edge before BTN_LONG fires (>= 2)
- REPEAT_COUNT, 4, cycles between auto-repeat BTN_PRESS pulses once long-press is reached (>= 2)
- CLOCK  input  1  system clock, all logic on rising edge
- CPU_RESET  input  1  reset; one clock; reset is synchronous and active-high
- BTN_IN  input  NUM_BTNS  debounced button levels, 1 = pressed, already synchronous to CLOCK
- BTN_PRESS  output  NUM_BTNS  one-cycle pulse per press edge and per auto-repeat
- BTN_RELEASE  output  NUM_BTNS  one-cycle pulse on release
- BTN_LONG  output  NUM_BTNS  one-cycle pulse when the hold reaches LONG_COUNT
- BTN_HELD  output  NUM_BTNS  level, high from the press pulse until the release pulse

## Operation
- Each channel has an independent FSM plus a down-counter.
- Counter width: $clog2(max(LONG_COUNT, REPEAT_COUNT) + 1).
- All outputs are registered.
- States and transitions:
  - ARM: entered on reset. Wait for BTN_IN[i] = 0, then go to IDLE. No pulses are emitted, so a button held through reset produces no events.
  - IDLE, BTN_IN[i] = 1: go to PRESSED, pulse BTN_PRESS, set BTN_HELD, load counter with LONG_COUNT-1.
  - PRESSED, BTN_IN[i] = 1: decrement the counter. At 0, go to HELD, pulse BTN_LONG, load counter with REPEAT_COUNT-1.
  - HELD, BTN_IN[i] = 1, counter at 0: pulse BTN_PRESS (auto-repeat only) and reload REPEAT_COUNT-1. Otherwise decrement.
  - PRESSED or HELD, BTN_IN[i] = 0: go to IDLE, pulse BTN_RELEASE, clear BTN_HELD, clear the counter.
- Release takes priority over a long or repeat threshold reached on the same edge. No BTN_LONG or BTN_PRESS is emitted on that edge.
- BTN_PRESS and BTN_RELEASE are never high in the same cycle on the same channel.
- BTN_LONG and BTN_PRESS never coincide on a channel.
- Reset asserted mid-operation:
  - All outputs go to 0 at the next edge.
  - The FSM goes to ARM and the counter clears.
  - No release pulse is generated.

## Timing
- All outputs reset to 0.
- Let edge k be the first rising edge at which an IDLE channel samples BTN_IN[i] = 1.
  - BTN_PRESS and the rise of BTN_HELD occur in the cycle after edge k (latency 1).
- BTN_LONG: cycle after edge k+LONG_COUNT, provided BTN_IN[i] was 1 at every edge k..k+LONG_COUNT.
- Auto-repeat BTN_PRESS: cycle after edge k+LONG_COUNT+n·REPEAT_COUNT, n >= 1, while held.
- Release at edge m (first edge with BTN_IN[i] = 0 in PRESSED/HELD):
  - BTN_RELEASE and the fall of BTN_HELD occur in the cycle after edge m.
  - A new press sampled at edge m+1 is accepted, giving BTN_PRESS after m+1.
- Minimum press: 1 cycle high gives PRESS, then RELEASE on consecutive cycles.
- ARM exit: the first edge with BTN_IN[i] = 0 moves the channel to IDLE. The earliest press is at the following edge.

## Configuration
- Macro: BTN_AUTO_REPEAT_EN.
- Defined: HELD emits periodic BTN_PRESS pulses as specified.
- Undefined:
  - HELD emits nothing until release.
  - Counter logic for repeat is removed.
  - BTN_LONG and BTN_RELEASE behaviour is unchanged.

## Test plan
All scenarios use NUM_BTNS=4, LONG_COUNT=8, REPEAT_COUNT=4.
- Reset with BTN_IN=4'b0001 held for 20 cycles after reset release, then released -> no pulses at all on channel 0. Press at the next edge -> BTN_PRESS[0] one cycle later.
- BTN_IN[1] high 3 cycles -> BTN_PRESS[1] after edge k, BTN_RELEASE[1] after edge k+3. BTN_HELD[1] high for exactly 3 cycles. No BTN_LONG.
- BTN_IN[2] high 20 cycles, macro defined -> BTN_PRESS at k, BTN_LONG at k+8, repeats at k+12 and k+16, release at k+20. Repeat check: 3 PRESS pulses total.
- Same stimulus, macro undefined -> PRESS at k, LONG at k+8, RELEASE at k+20, no repeats.
- BTN_IN[3] falls exactly at edge k+8 -> BTN_RELEASE[3] only, no BTN_LONG[3]. All four channels pressed simultaneously -> four independent, identical pulse streams.
- CPU_RESET asserted for 1 cycle during HELD on channel 2 -> all outputs 0 next cycle, no BTN_RELEASE. Channel stays silent until BTN_IN[2] returns to 0.

Source files
------------

// File: rtl/btn_event_gen.sv
// Per-button event generator: turns debounced levels into press/release/long/held events.
// Optional auto-repeat of BTN_PRESS while held is enabled by defining BTN_AUTO_REPEAT_EN.
module btn_event_gen #(
   parameter int NUM_BTNS     = 4,
   parameter int LONG_COUNT   = 8,
   parameter int REPEAT_COUNT = 4
) (
   input  logic                CLOCK,
   input  logic                CPU_RESET,
   input  logic [NUM_BTNS-1:0] BTN_IN,
   output logic [NUM_BTNS-1:0] BTN_PRESS,
   output logic [NUM_BTNS-1:0] BTN_RELEASE,
   output logic [NUM_BTNS-1:0] BTN_LONG,
   output logic [NUM_BTNS-1:0] BTN_HELD
);

   localparam int MAX_COUNT = (LONG_COUNT > REPEAT_COUNT) ? LONG_COUNT : REPEAT_COUNT;
   localparam int CNT_W     = $clog2(MAX_COUNT + 1);
   localparam logic [CNT_W-1:0] LONG_LOAD = CNT_W'(LONG_COUNT - 1);
`ifdef BTN_AUTO_REPEAT_EN
   localparam logic [CNT_W-1:0] REPEAT_LOAD = CNT_W'(REPEAT_COUNT - 1);
`endif

   typedef enum logic [1:0] {ARM, IDLE, PRESSED, HELD} state_t;

   state_t           state_q [NUM_BTNS];
   state_t           state_d [NUM_BTNS];
   logic [CNT_W-1:0] cnt_q   [NUM_BTNS];
   logic [CNT_W-1:0] cnt_d   [NUM_BTNS];
   logic [NUM_BTNS-1:0] press_d, release_d, long_d, held_d;

   always_ff @(posedge CLOCK) begin
      if (CPU_RESET) begin
         for (int i = 0; i < NUM_BTNS; i++) begin
            state_q[i] <= ARM;
            cnt_q[i]   <= '0;
         end
         BTN_PRESS   <= '0;
         BTN_RELEASE <= '0;
         BTN_LONG    <= '0;
         BTN_HELD    <= '0;
      end else begin
         for (int i = 0; i < NUM_BTNS; i++) begin
            state_q[i] <= state_d[i];
            cnt_q[i]   <= cnt_d[i];
         end
         BTN_PRESS   <= press_d;
         BTN_RELEASE <= release_d;
         BTN_LONG    <= long_d;
         BTN_HELD    <= held_d;
      end
   end

   // Release is checked first in PRESSED/HELD so it wins over a threshold on the same edge.
   always_comb begin
      press_d   = '0;
      release_d = '0;
      long_d    = '0;
      held_d    = BTN_HELD;
      for (int i = 0; i < NUM_BTNS; i++) begin
         state_d[i] = state_q[i];
         cnt_d[i]   = cnt_q[i];
         case (state_q[i])
            ARM: begin
               if (!BTN_IN[i]) state_d[i] = IDLE;
            end
            IDLE: begin
               if (BTN_IN[i]) begin
                  state_d[i] = PRESSED;
                  press_d[i] = 1'b1;
                  held_d[i]  = 1'b1;
                  cnt_d[i]   = LONG_LOAD;
               end
            end
            PRESSED: begin
               if (!BTN_IN[i]) begin
                  state_d[i]   = IDLE;
                  release_d[i] = 1'b1;
                  held_d[i]    = 1'b0;
                  cnt_d[i]     = '0;
               end else if (cnt_q[i] == '0) begin
                  state_d[i] = HELD;
                  long_d[i]  = 1'b1;
`ifdef BTN_AUTO_REPEAT_EN
                  cnt_d[i]   = REPEAT_LOAD;
`else
                  cnt_d[i]   = '0;
`endif
               end else begin
                  cnt_d[i] = cnt_q[i] - 1'b1;
               end
            end
            HELD: begin
               if (!BTN_IN[i]) begin
                  state_d[i]   = IDLE;
                  release_d[i] = 1'b1;
                  held_d[i]    = 1'b0;
                  cnt_d[i]     = '0;
               end
`ifdef BTN_AUTO_REPEAT_EN
               else if (cnt_q[i] == '0) begin
                  press_d[i] = 1'b1;
                  cnt_d[i]   = REPEAT_LOAD;
               end else begin
                  cnt_d[i] = cnt_q[i] - 1'b1;
               end
`endif
            end
            default: begin
               state_d[i] = ARM;
               cnt_d[i]   = '0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_btn_event_gen.sv
// Self-checking bench for btn_event_gen: per-cycle scoreboard against a hold-time model,
// plus table-driven event-count vectors and hand-written reset sequences.
module tb_btn_event_gen;

   localparam int NUM_BTNS     = 4;
   localparam int LONG_COUNT   = 8;
   localparam int REPEAT_COUNT = 4;
`ifdef BTN_AUTO_REPEAT_EN
   localparam bit AUTO_REP = 1'b1;
`else
   localparam bit AUTO_REP = 1'b0;
`endif

   logic                clock = 1'b0;
   logic                cpu_reset = 1'b1;
   logic [NUM_BTNS-1:0] btn_in = '0;
   logic [NUM_BTNS-1:0] btn_press, btn_release, btn_long, btn_held;

   always #5 clock = ~clock;

   btn_event_gen #(
      .NUM_BTNS(NUM_BTNS), .LONG_COUNT(LONG_COUNT), .REPEAT_COUNT(REPEAT_COUNT)
   ) dut (
      .CLOCK(clock), .CPU_RESET(cpu_reset), .BTN_IN(btn_in),
      .BTN_PRESS(btn_press), .BTN_RELEASE(btn_release),
      .BTN_LONG(btn_long), .BTN_HELD(btn_held)
   );

   typedef struct {
      logic [NUM_BTNS-1:0] press;
      logic [NUM_BTNS-1:0] rel;
      logic [NUM_BTNS-1:0] lng;
      logic [NUM_BTNS-1:0] held;
   } exp_t;

   typedef struct {
      logic [NUM_BTNS-1:0] btn;
      int hold;
      int exp_press_rep;
      int exp_press_norep;
      int exp_long;
      int exp_rel;
      int exp_held;
   } vec_t;

   exp_t sb_q[$];
   exp_t m_out = '{default: '0};
   bit   m_arm    [NUM_BTNS];
   bit   m_active [NUM_BTNS];
   int   m_t      [NUM_BTNS];

   int cnt_press [NUM_BTNS];
   int cnt_rel   [NUM_BTNS];
   int cnt_long  [NUM_BTNS];
   int cnt_held  [NUM_BTNS];

   int checks = 0;
   int errors = 0;

   task automatic check(string name, logic [31:0] act, logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   // Model counts edges held since the press edge rather than tracking a down-counter.
   task automatic modelEdge(logic rst, logic [NUM_BTNS-1:0] btn);
      for (int i = 0; i < NUM_BTNS; i++) begin
         m_out.press[i] = 1'b0;
         m_out.rel[i]   = 1'b0;
         m_out.lng[i]   = 1'b0;
         if (rst) begin
            m_arm[i]    = 1'b1;
            m_active[i] = 1'b0;
            m_t[i]      = 0;
         end else if (m_arm[i]) begin
            if (!btn[i]) m_arm[i] = 1'b0;
         end else if (!m_active[i]) begin
            if (btn[i]) begin
               m_active[i]    = 1'b1;
               m_t[i]         = 0;
               m_out.press[i] = 1'b1;
            end
         end else if (!btn[i]) begin
            m_active[i]  = 1'b0;
            m_out.rel[i] = 1'b1;
         end else begin
            m_t[i]++;
            if (m_t[i] == LONG_COUNT)
               m_out.lng[i] = 1'b1;
            else if (AUTO_REP && m_t[i] > LONG_COUNT && ((m_t[i] - LONG_COUNT) % REPEAT_COUNT) == 0)
               m_out.press[i] = 1'b1;
         end
         m_out.held[i] = m_active[i];
      end
   endtask

   task automatic clearCounts();
      for (int i = 0; i < NUM_BTNS; i++) begin
         cnt_press[i] = 0;
         cnt_rel[i]   = 0;
         cnt_long[i]  = 0;
         cnt_held[i]  = 0;
      end
   endtask

   task automatic checkOutput();
      exp_t e;
      if (sb_q.size() == 0) begin
         checks++;
         errors++;
         $display("[TB] FAIL scoreboard_empty actual=0 required=1");
      end else begin
         e = sb_q.pop_front();
         check("cycle_outputs", {16'h0, btn_press, btn_release, btn_long, btn_held},
               {16'h0, e.press, e.rel, e.lng, e.held});
      end
      for (int i = 0; i < NUM_BTNS; i++) begin
         cnt_press[i] += int'(btn_press[i]);
         cnt_rel[i]   += int'(btn_release[i]);
         cnt_long[i]  += int'(btn_long[i]);
         cnt_held[i]  += int'(btn_held[i]);
      end
   endtask

   task automatic applyStimulus(logic rst, logic [NUM_BTNS-1:0] btn);
      @(negedge clock);
      cpu_reset = rst;
      btn_in    = btn;
      modelEdge(rst, btn);
      sb_q.push_back(m_out);
      @(posedge clock);
      #1;
      checkOutput();
   endtask

   vec_t vecs[8];

   initial begin
      vecs[0] = '{4'b0010,  3, 1, 1, 0, 1,  3};
      vecs[1] = '{4'b0001,  1, 1, 1, 0, 1,  1};
      vecs[2] = '{4'b1000,  8, 1, 1, 0, 1,  8};
      vecs[3] = '{4'b1000,  9, 1, 1, 1, 1,  9};
      vecs[4] = '{4'b0100, 20, 3, 1, 1, 1, 20};
      vecs[5] = '{4'b1111, 13, 2, 1, 1, 1, 13};
      vecs[6] = '{4'b0100, 16, 2, 1, 1, 1, 16};
      vecs[7] = '{4'b0100, 17, 3, 1, 1, 1, 17};

      for (int i = 0; i < NUM_BTNS; i++) begin
         m_arm[i] = 1'b1;
         m_active[i] = 1'b0;
         m_t[i] = 0;
      end
      clearCounts();

      // Button 0 held through reset must stay silent until it is let go.
      repeat (3) applyStimulus(1'b1, 4'b0001);
      check("reset_state", {16'h0, btn_press, btn_release, btn_long, btn_held}, 32'h0);
      clearCounts();
      repeat (20) applyStimulus(1'b0, 4'b0001);
      applyStimulus(1'b0, 4'b0000);
      check("arm_silent", cnt_press[0] + cnt_rel[0] + cnt_long[0] + cnt_held[0], 0);
      applyStimulus(1'b0, 4'b0001);
      check("press_after_arm", {31'h0, btn_press[0]}, 32'h1);
      repeat (2) applyStimulus(1'b0, 4'b0000);

      for (int v = 0; v < 8; v++) begin
         repeat (2) applyStimulus(1'b0, 4'b0000);
         clearCounts();
         repeat (vecs[v].hold) applyStimulus(1'b0, vecs[v].btn);
         repeat (3) applyStimulus(1'b0, 4'b0000);
         for (int ch = 0; ch < NUM_BTNS; ch++) begin
            if (vecs[v].btn[ch]) begin
               check("vec_press", cnt_press[ch],
                     AUTO_REP ? vecs[v].exp_press_rep : vecs[v].exp_press_norep);
               check("vec_long", cnt_long[ch], vecs[v].exp_long);
               check("vec_release", cnt_rel[ch], vecs[v].exp_rel);
               check("vec_held", cnt_held[ch], vecs[v].exp_held);
            end
         end
      end

      // Reset while channel 2 is in HELD: outputs clear, no release, silent until released.
      repeat (2) applyStimulus(1'b0, 4'b0000);
      repeat (10) applyStimulus(1'b0, 4'b0100);
      applyStimulus(1'b1, 4'b0100);
      check("reset_mid_held", {16'h0, btn_press, btn_release, btn_long, btn_held}, 32'h0);
      clearCounts();
      repeat (6) applyStimulus(1'b0, 4'b0100);
      repeat (2) applyStimulus(1'b0, 4'b0000);
      check("post_reset_silent", cnt_press[2] + cnt_rel[2] + cnt_long[2] + cnt_held[2], 0);
      applyStimulus(1'b0, 4'b0100);
      check("press_after_reset", {31'h0, btn_press[2]}, 32'h1);
      repeat (3) applyStimulus(1'b0, 4'b0000);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
